mouse_master_sm: RTL

Master sequencer for the PS/2 mouse link. It drives the byte transmitter and the byte receiver to run the power-up handshake: reset command, acknowledge, self-test and ID, then enable data reporting. After initialisation it assembles the 3-byte movement packets from the receiver. It sits between the two byte-level PS/2 engines and the mouse transceiver top, which turns its packet outputs into position and button registers.

---
 rtl/mouse_pkg.sv | 33 +++
 rtl/mouse_master_sm.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mouse_pkg.sv
// Shared encodings for the PS/2 mouse master sequencer: state numbers,
// command/response bytes and receiver error-code bit positions.
package mouse_pkg;

    typedef enum logic [3:0] {
        ST_INIT_WAIT        = 4'd0,
        ST_SEND_RESET       = 4'd1,
        ST_WAIT_SENT_RESET  = 4'd2,
        ST_WAIT_ACK_RESET   = 4'd3,
        ST_WAIT_SELFTEST    = 4'd4,
        ST_WAIT_ID          = 4'd5,
        ST_SEND_ENABLE      = 4'd6,
        ST_WAIT_SENT_ENABLE = 4'd7,
        ST_WAIT_ACK_ENABLE  = 4'd8,
        ST_READ_B1          = 4'd9,
        ST_READ_B2          = 4'd10,
        ST_READ_B3          = 4'd11,
        ST_PACKET_OUT       = 4'd12
    } master_state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_SELFTEST = 8'hAA;
    localparam logic [7:0] RSP_ID       = 8'h00;

    localparam int ERR_PARITY_BIT = 0;
    localparam int ERR_STOP_BIT   = 1;

    // Bit 3 of the first movement byte is always 1; used to resynchronise.
    localparam int STATUS_SYNC_BIT = 3;

endpackage

// File: rtl/mouse_master_sm.sv
// PS/2 mouse master sequencer: runs the reset/self-test/enable handshake,
// then assembles 3-byte movement packets from the byte receiver.
module mouse_master_sm
    import mouse_pkg::*;
#(
    parameter int T_INIT_WAIT = 5_000_000,
    parameter int T_TIMEOUT   = 100_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT,
    output logic [3:0] MASTER_STATE
);

    localparam int T_MAX = (T_INIT_WAIT > T_TIMEOUT) ? T_INIT_WAIT : T_TIMEOUT;
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] INIT_LIMIT    = CW'(T_INIT_WAIT);
    localparam logic [CW-1:0] TIMEOUT_LIMIT = CW'(T_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX       = '1;

    master_state_t state;
    master_state_t next_state;
    logic [CW-1:0] cnt;
    logic [7:0]    hold_status;
    logic [7:0]    hold_dx;
    logic [7:0]    hold_dy;
    logic          good_byte;
    logic          bad_byte;
    logic          timed_out;

    assign good_byte = BYTE_READY && !BYTE_ERROR_CODE[ERR_PARITY_BIT]
                                  && !BYTE_ERROR_CODE[ERR_STOP_BIT];
    assign bad_byte  = BYTE_READY && !good_byte;
    assign timed_out = (cnt >= TIMEOUT_LIMIT);

    assign MASTER_STATE = state;

    // A received byte is checked before the watchdog, so a good byte in the
    // timeout cycle wins.
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT_WAIT: begin
                if (cnt >= INIT_LIMIT) next_state = ST_SEND_RESET;
            end
            ST_SEND_RESET: next_state = ST_WAIT_SENT_RESET;
            ST_WAIT_SENT_RESET: begin
                if (BYTE_SENT)      next_state = ST_WAIT_ACK_RESET;
                else if (timed_out) next_state = ST_INIT_WAIT;
            end
            ST_WAIT_ACK_RESET: begin
                if (BYTE_READY)
                    next_state = (good_byte && BYTE_READ == RSP_ACK) ? ST_WAIT_SELFTEST : ST_INIT_WAIT;
                else if (timed_out)
                    next_state = ST_INIT_WAIT;
            end
            ST_WAIT_SELFTEST: begin
                if (BYTE_READY)
                    next_state = (good_byte && BYTE_READ == RSP_SELFTEST) ? ST_WAIT_ID : ST_INIT_WAIT;
                else if (timed_out)
                    next_state = ST_INIT_WAIT;
            end
            ST_WAIT_ID: begin
                if (BYTE_READY)
                    next_state = (good_byte && BYTE_READ == RSP_ID) ? ST_SEND_ENABLE : ST_INIT_WAIT;
                else if (timed_out)
                    next_state = ST_INIT_WAIT;
            end
            ST_SEND_ENABLE: next_state = ST_WAIT_SENT_ENABLE;
            ST_WAIT_SENT_ENABLE: begin
                if (BYTE_SENT)      next_state = ST_WAIT_ACK_ENABLE;
                else if (timed_out) next_state = ST_INIT_WAIT;
            end
            ST_WAIT_ACK_ENABLE: begin
                if (BYTE_READY)
                    next_state = (good_byte && BYTE_READ == RSP_ACK) ? ST_READ_B1 : ST_INIT_WAIT;
                else if (timed_out)
                    next_state = ST_INIT_WAIT;
            end
            ST_READ_B1: begin
                if (good_byte && BYTE_READ[STATUS_SYNC_BIT]) next_state = ST_READ_B2;
            end
            ST_READ_B2: begin
                if (good_byte)                  next_state = ST_READ_B3;
                else if (bad_byte || timed_out) next_state = ST_READ_B1;
            end
            ST_READ_B3: begin
                if (good_byte)                  next_state = ST_PACKET_OUT;
                else if (bad_byte || timed_out) next_state = ST_READ_B1;
            end
            ST_PACKET_OUT: next_state = ST_READ_B1;
            default:       next_state = ST_INIT_WAIT;
        endcase
    end

    // Outputs other than the packet are decoded from the next state so they
    // line up with the state they belong to.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= ST_INIT_WAIT;
            cnt            <= '0;
            SEND_BYTE      <= 1'b0;
            BYTE_TO_SEND   <= 8'h00;
            READ_ENABLE    <= 1'b0;
            hold_status    <= 8'h00;
            hold_dx        <= 8'h00;
            hold_dy        <= 8'h00;
            MOUSE_STATUS   <= 8'h00;
            MOUSE_DX       <= 8'h00;
            MOUSE_DY       <= 8'h00;
            SEND_INTERRUPT <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CW'(1);

            SEND_BYTE <= (next_state == ST_SEND_RESET) || (next_state == ST_SEND_ENABLE);
            if (next_state == ST_SEND_RESET)
                BYTE_TO_SEND <= CMD_RESET;
            else if (next_state == ST_SEND_ENABLE)
                BYTE_TO_SEND <= CMD_ENABLE;

            READ_ENABLE <= (next_state == ST_WAIT_ACK_RESET) || (next_state == ST_WAIT_SELFTEST) ||
                           (next_state == ST_WAIT_ID)        || (next_state >= ST_WAIT_ACK_ENABLE);

            if (state == ST_READ_B1 && good_byte && BYTE_READ[STATUS_SYNC_BIT])
                hold_status <= BYTE_READ;
            if (state == ST_READ_B2 && good_byte)
                hold_dx <= BYTE_READ;
            if (state == ST_READ_B3 && good_byte)
                hold_dy <= BYTE_READ;

            SEND_INTERRUPT <= (state == ST_PACKET_OUT);
            if (state == ST_PACKET_OUT) begin
                MOUSE_STATUS <= hold_status;
                MOUSE_DX     <= hold_dx;
                MOUSE_DY     <= hold_dy;
            end
        end
    end

endmodule
